// File: rtl/music_sequencer_pkg.sv
// Shared audio definitions: track and FSM encodings, sample/address widths,
// and the game-status to track mapping.
package music_sequencer_pkg;

  localparam int SAMPLE_W = 17;
  localparam int ADDR_W   = 17;

  typedef enum logic [1:0] {
    TRK_SILENT = 2'd0,
    TRK_1      = 2'd1,
    TRK_2      = 2'd2,
    TRK_3      = 2'd3
  } track_e;

  typedef enum logic [1:0] {
    ST_SILENT = 2'd0,
    ST_PLAY   = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  function automatic track_e status_to_track(input logic [3:0] status);
    case (status)
      4'd1, 4'd2, 4'd5: return TRK_1;
      4'd4:             return TRK_2;
      4'd3:             return TRK_3;
      default:          return TRK_SILENT;
    endcase
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-period down-counter: tick is high while running with the count at 0.
// restart reloads CLK_DIV-1 and suppresses the tick; the count is frozen when run is low.
module sample_tick_gen #(
  parameter int CLK_DIV = 1563
) (
  input  logic Clk,
  input  logic Reset,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = RELOAD;
    end else if (run) begin
      cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && !restart && (cnt_q == '0);

endmodule

// File: rtl/music_sequencer.sv
// Steps the shared ROM address once per sample period for the track chosen by the
// game status, and presents the ROM word as a held sample with a one-cycle strobe.
module music_sequencer
  import music_sequencer_pkg::*;
#(
  parameter int                  CLK_DIV    = 1563,
  parameter int                  TRACK_LEN1 = 65536,
  parameter int                  TRACK_LEN2 = 65536,
  parameter int                  TRACK_LEN3 = 65536,
  parameter logic [SAMPLE_W-1:0] SILENCE    = 17'h00000
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [3:0]          status,
  input  logic                pause,
  input  logic [SAMPLE_W-1:0] music_content1,
  input  logic [SAMPLE_W-1:0] music_content2,
  input  logic [SAMPLE_W-1:0] music_content3,
  output logic [ADDR_W-1:0]   Add,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic [1:0]          track,
  output logic                looped
);

  state_e                state_q, state_d;
  track_e                track_q, track_d;
  logic [ADDR_W-1:0]     add_q, add_d;
  logic [SAMPLE_W-1:0]   sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic                  looped_q, looped_d;

  track_e                new_trk;
  logic                  change;
  logic                  run;
  logic                  tick;
  logic [ADDR_W-1:0]     last_addr;
  logic [SAMPLE_W-1:0]   rom_word;

  assign new_trk = status_to_track(status);
  assign change  = (new_trk != track_q);
  // A pending pause or track switch blocks the tick in the same cycle.
  assign run     = (state_q == ST_PLAY) && !pause && !change;

  sample_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .Clk     (Clk),
    .Reset   (Reset),
    .run     (run),
    .restart (change),
    .tick    (tick)
  );

  always_comb begin
    last_addr = '0;
    rom_word  = SILENCE;
    case (track_q)
      TRK_1: begin
        last_addr = ADDR_W'(TRACK_LEN1 - 1);
        rom_word  = music_content1;
      end
      TRK_2: begin
        last_addr = ADDR_W'(TRACK_LEN2 - 1);
        rom_word  = music_content2;
      end
      TRK_3: begin
        last_addr = ADDR_W'(TRACK_LEN3 - 1);
        rom_word  = music_content3;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    track_d  = track_q;
    add_d    = add_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    looped_d = 1'b0;
    if (change) begin
      track_d  = new_trk;
      add_d    = '0;
      sample_d = SILENCE;
      if (new_trk == TRK_SILENT) begin
        state_d = ST_SILENT;
      end else begin
        state_d = pause ? ST_HOLD : ST_PLAY;
      end
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (pause) begin
            state_d = ST_HOLD;
          end else if (tick) begin
            sample_d = rom_word;
            valid_d  = 1'b1;
            if (add_q == last_addr) begin
              add_d    = '0;
              looped_d = 1'b1;
            end else begin
              add_d = add_q + ADDR_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (!pause) state_d = ST_PLAY;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_SILENT;
      track_q  <= TRK_SILENT;
      add_q    <= '0;
      sample_q <= SILENCE;
      valid_q  <= 1'b0;
      looped_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      track_q  <= track_d;
      add_q    <= add_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      looped_q <= looped_d;
    end
  end

  assign Add          = add_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign track        = track_q;
  assign looped       = looped_q;

endmodule
